// File: rtl/rmsnorm_pkg.sv
// Shared defaults and FSM encoding for the RMS normalisation controller.
package rmsnorm_pkg;

  localparam int VEC_LEN_DEF  = 64;
  localparam int X_W_DEF      = 8;
  localparam int D_W_DEF      = 14;
  localparam int OUT_FRAC_DEF = 5;
  localparam int R_W          = 16;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    EMIT  = 2'd3
  } state_e;

  localparam logic [1:0] ST_ACCUM = 2'(ACCUM);
  localparam logic [1:0] ST_REQ   = 2'(REQ);
  localparam logic [1:0] ST_WAIT  = 2'(WAIT);
  localparam logic [1:0] ST_EMIT  = 2'(EMIT);

endpackage

// File: rtl/rmsnorm_ctrl_vec_buf.sv
// Element buffer: simple dual-port memory with a registered read port,
// written once per accepted element and replayed during emission.
module vec_buf #(
  parameter int DEPTH = 64,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic signed [W-1:0]      wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic signed [W-1:0]      rd_data
);

  logic [W-1:0] mem [DEPTH];

  // Write port and registered read; contents are never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/rmsnorm_ctrl.sv
// RMS normalisation controller: accumulates a vector's mean square, requests
// 1/sqrt(mean) from an external unit and streams the scaled elements back out.
module rmsnorm_ctrl
  import rmsnorm_pkg::*;
#(
  parameter int VEC_LEN  = VEC_LEN_DEF,
  parameter int X_W      = X_W_DEF,
  parameter int D_W      = D_W_DEF,
  parameter int OUT_FRAC = OUT_FRAC_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic signed [X_W-1:0] x_i,
  output logic                  isq_valid_o,
  output logic [D_W-1:0]        isq_d_o,
  input  logic                  isq_valid_i,
  input  logic [R_W-1:0]        isq_result_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic signed [X_W-1:0] y_o
);

  localparam int LOG2  = $clog2(VEC_LEN);
  localparam int SQ_W  = 2 * X_W - 1;
  localparam int SUM_W = SQ_W + LOG2;
  localparam int P_W   = X_W + 17;
  localparam int SH    = 15 - OUT_FRAC;
  localparam logic [LOG2:0]         LAST_IDX = (LOG2+1)'(VEC_LEN - 1);
  localparam logic [LOG2:0]         END_IDX  = (LOG2+1)'(VEC_LEN);
  localparam logic [SUM_W-1:0]      D_MAX    = SUM_W'({D_W{1'b1}});
  localparam logic signed [P_W-1:0] RND      = P_W'(1 << (SH - 1));
  localparam logic signed [P_W-1:0] Y_MAX    = P_W'((1 << (X_W - 1)) - 1);
  localparam logic signed [P_W-1:0] Y_MIN    = ~Y_MAX;

  logic [1:0]              state_r, state_nx_s;
  logic [LOG2:0]           cnt_r;
  logic [SUM_W-1:0]        sum_r, sum_nx_s, mean_s;
  logic [SQ_W-1:0]         sq_s;
  logic [D_W-1:0]          d_sat_s, isq_d_r;
  logic [R_W-1:0]          r_r, r_s;
  logic                    ready_r, isq_valid_r, valid_r;
  logic signed [X_W-1:0]   y_r, y_sat_s, rd_data_s;
  logic [LOG2-1:0]         rd_addr_s;
  logic signed [P_W-1:0]   x_ext_s, r_ext_s, rnd_s, scaled_s;
  logic                    hs_in_s, last_in_s, capture_s, out_hs_s, done_s, load_s;

  // cnt_r counts writes in ACCUM and elements loaded into y_r during emission.
  assign hs_in_s   = valid_i & ready_r & (state_r == ST_ACCUM);
  assign last_in_s = hs_in_s & (cnt_r == LAST_IDX);
  assign capture_s = isq_valid_i & (state_r == ST_WAIT);
  assign out_hs_s  = valid_r & ready_i & (state_r == ST_EMIT);
  assign done_s    = out_hs_s & (cnt_r == END_IDX);
  assign load_s    = capture_s | (out_hs_s & ~done_s);

  assign sq_s      = SQ_W'(x_i * x_i);
  assign sum_nx_s  = sum_r + SUM_W'(sq_s);
  assign mean_s    = sum_nx_s >> LOG2;
  // Prefetch the element that the next load will need.
  assign rd_addr_s = load_s ? (cnt_r[LOG2-1:0] + LOG2'(1)) : cnt_r[LOG2-1:0];

  vec_buf #(.DEPTH(VEC_LEN), .W(X_W)) u_buf (
    .clk     (clk_i),
    .we      (hs_in_s),
    .wr_addr (cnt_r[LOG2-1:0]),
    .wr_data (x_i),
    .rd_addr (rd_addr_s),
    .rd_data (rd_data_s)
  );

  // Mean-square saturation and scale selection (bypass r on the capture cycle).
  always_comb begin
    d_sat_s = mean_s[D_W-1:0];
    r_s     = r_r;
    if (mean_s > D_MAX) begin
      d_sat_s = {D_W{1'b1}};
    end else begin
      d_sat_s = mean_s[D_W-1:0];
    end
    if (capture_s) begin
      r_s = isq_result_i;
    end else begin
      r_s = r_r;
    end
  end

  assign x_ext_s  = P_W'(rd_data_s);
  assign r_ext_s  = {{(P_W-R_W){1'b0}}, r_s};
  assign rnd_s    = x_ext_s * r_ext_s + RND;
  assign scaled_s = rnd_s >>> SH;

  // Output saturation to the signed element range.
  always_comb begin
    y_sat_s = scaled_s[X_W-1:0];
    if (scaled_s > Y_MAX) begin
      y_sat_s = Y_MAX[X_W-1:0];
    end else if (scaled_s < Y_MIN) begin
      y_sat_s = Y_MIN[X_W-1:0];
    end else begin
      y_sat_s = scaled_s[X_W-1:0];
    end
  end

  // FSM next-state.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_ACCUM: if (last_in_s) state_nx_s = ST_REQ;  else state_nx_s = ST_ACCUM;
      ST_REQ:   state_nx_s = ST_WAIT;
      ST_WAIT:  if (capture_s) state_nx_s = ST_EMIT; else state_nx_s = ST_WAIT;
      ST_EMIT:  if (done_s)    state_nx_s = ST_ACCUM; else state_nx_s = ST_EMIT;
      default:  state_nx_s = ST_ACCUM;
    endcase
  end

  // State, input-side ready, element counter and square accumulator.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_ACCUM;
      ready_r <= 1'b0;
      cnt_r   <= '0;
      sum_r   <= '0;
    end else begin
      state_r <= state_nx_s;
      ready_r <= (state_nx_s == ST_ACCUM);
      if (last_in_s || done_s) begin
        cnt_r <= '0;
      end else if (hs_in_s || load_s) begin
        cnt_r <= cnt_r + (LOG2+1)'(1);
      end else begin
        cnt_r <= cnt_r;
      end
      if (hs_in_s) begin
        sum_r <= sum_nx_s;
      end else if (done_s) begin
        sum_r <= '0;
      end else begin
        sum_r <= sum_r;
      end
    end
  end

  // inv_sqrt request pulse, held mean word and captured scale.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      isq_valid_r <= 1'b0;
      isq_d_r     <= '0;
      r_r         <= '0;
    end else begin
      isq_valid_r <= last_in_s;
      if (last_in_s) begin
        isq_d_r <= d_sat_s;
      end else begin
        isq_d_r <= isq_d_r;
      end
      if (capture_s) begin
        r_r <= isq_result_i;
      end else begin
        r_r <= r_r;
      end
    end
  end

  // Registered output stage; holds while the consumer stalls.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_r <= 1'b0;
      y_r     <= '0;
    end else if (load_s) begin
      valid_r <= 1'b1;
      y_r     <= y_sat_s;
    end else if (done_s) begin
      valid_r <= 1'b0;
      y_r     <= y_r;
    end else begin
      valid_r <= valid_r;
      y_r     <= y_r;
    end
  end

  assign ready_o     = ready_r;
  assign isq_valid_o = isq_valid_r;
  assign isq_d_o     = isq_d_r;
  assign valid_o     = valid_r;
  assign y_o         = y_r;

endmodule

// File: tb/tb_rmsnorm_ctrl.sv
// Self-checking bench for rmsnorm_ctrl with a 2-cycle inv_sqrt stub and an
// arithmetic reference model of mean-square and output scaling.
module tb_rmsnorm_ctrl;

  localparam int VL = 64;
  localparam int DW = 14;
  localparam int OF = 5;

  logic              clk = 1'b0;
  logic              rst_ni, valid_i, ready_o, isq_valid_o, isq_valid_i, valid_o, ready_i;
  logic signed [7:0] x_i, y_o;
  logic [DW-1:0]     isq_d_o;
  logic [15:0]       isq_result_i;

  int errors = 0;
  int checks = 0;
  int vec[VL];

  rmsnorm_ctrl dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .x_i          (x_i),
    .isq_valid_o  (isq_valid_o),
    .isq_d_o      (isq_d_o),
    .isq_valid_i  (isq_valid_i),
    .isq_result_i (isq_result_i),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .y_o          (y_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int model_mean();
    int s = 0;
    for (int i = 0; i < VL; i++) s += vec[i] * vec[i];
    s = s / VL;
    if (s > (1 << DW) - 1) s = (1 << DW) - 1;
    return s;
  endfunction

  function automatic int model_y(input int x, input int r);
    int p;
    p = (x * r + (1 << (14 - OF))) >>> (15 - OF);
    if (p > 127) p = 127;
    if (p < -128) p = -128;
    return p;
  endfunction

  // rmode: 0 ready_i always 1, 1 toggling, 2 random. abort_at >= 0 resets mid-emission.
  task automatic run_vector(input int r, input int rmode, input int abort_at, input bit spur);
    int i, k, cyc, exp_mean;
    logic signed [7:0] held_y;
    bit stalled, tog;
    exp_mean = model_mean();
    i = 0; cyc = 0;
    while (i < VL && cyc < 6 * VL) begin
      @(negedge clk); cyc++;
      valid_i      = ($urandom_range(0, 3) != 0);
      x_i          = 8'(vec[i]);
      isq_valid_i  = spur && ($urandom_range(0, 3) == 0);
      isq_result_i = 16'($urandom);
      if (valid_i && ready_o) i++;
    end
    check("feed_done", i, VL);
    @(negedge clk);
    valid_i = 1'b0; isq_valid_i = 1'b0; x_i = 8'($urandom);
    check("isq_pulse", isq_valid_o, 1);
    check("isq_d", isq_d_o, exp_mean);
    check("ready_req", ready_o, 0);
    @(negedge clk);
    check("isq_pulse_end", isq_valid_o, 0);
    @(negedge clk);
    isq_valid_i = 1'b1; isq_result_i = 16'(r);
    @(negedge clk);
    isq_valid_i = 1'b0; isq_result_i = 16'($urandom);
    k = 0; cyc = 0; stalled = 1'b0; tog = 1'b0; held_y = '0;
    while (k < VL && cyc < 6 * VL) begin
      if (abort_at == k) begin
        rst_ni = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        #1;
        check("rst_valid", valid_o, 0);
        check("rst_ready", ready_o, 0);
        check("rst_y", y_o, 0);
        @(negedge clk); rst_ni = 1'b1;
        @(negedge clk);
        check("rst_ready_after", ready_o, 1);
        return;
      end
      check("valid_cont", valid_o, 1);
      check("ready_emit", ready_o, 0);
      if (stalled) check("stall_y", y_o, held_y);
      tog     = ~tog;
      ready_i = (rmode == 0) ? 1'b1 : (rmode == 1) ? tog : 1'($urandom_range(0, 1));
      valid_i = 1'($urandom_range(0, 1));
      x_i     = 8'($urandom);
      if (valid_o && ready_i) begin
        check("y", y_o, model_y(vec[k], r));
        k++;
        stalled = 1'b0;
      end else begin
        stalled = valid_o;
        held_y  = y_o;
      end
      @(negedge clk); cyc++;
    end
    valid_i = 1'b0; ready_i = 1'b1;
    check("emit_done", k, VL);
    check("valid_end", valid_o, 0);
    check("ready_end", ready_o, 1);
    check("isq_d_hold", isq_d_o, exp_mean);
  endtask

  initial begin
    int amp;
    rst_ni = 1'b0; valid_i = 1'b0; x_i = '0; isq_valid_i = 1'b0;
    isq_result_i = '0; ready_i = 1'b1;
    #12;
    check("reset_ready", ready_o, 0);
    check("reset_valid", valid_o, 0);
    check("reset_isq_valid", isq_valid_o, 0);
    check("reset_isq_d", isq_d_o, 0);
    check("reset_y", y_o, 0);
    @(negedge clk); rst_ni = 1'b1;
    check("ready_at_release", ready_o, 0);
    @(negedge clk);
    check("ready_after_release", ready_o, 1);

    for (int i = 0; i < VL; i++) vec[i] = 16;
    run_vector(2048, 0, -1, 1'b0);
    for (int i = 0; i < VL; i++) vec[i] = (i % 2 == 0) ? 8 : -8;
    run_vector(4096, 0, -1, 1'b0);
    for (int i = 0; i < VL; i++) vec[i] = -128;
    run_vector(256, 0, -1, 1'b0);
    for (int i = 0; i < VL; i++) vec[i] = 0;
    run_vector(16'hFFFF, 0, -1, 1'b1);
    for (int i = 0; i < VL; i++) vec[i] = 16;
    run_vector(2048, 1, -1, 1'b0);
    run_vector(2048, 0, 10, 1'b0);
    run_vector(2048, 0, -1, 1'b0);

    for (int n = 0; n < 8; n++) begin
      case ($urandom_range(0, 3))
        0:       amp = 4;
        1:       amp = 16;
        2:       amp = 64;
        default: amp = 128;
      endcase
      for (int i = 0; i < VL; i++) vec[i] = int'($urandom_range(0, 2 * amp - 1)) - amp;
      run_vector(int'($urandom_range(0, 65535)), 2, -1, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rmsnorm_ctrl.md
RMSNORM_CTRL -- requirements
Module: rmsnorm_ctrl

Interface
REQ-001 Parameter VEC_LEN, default 64, elements per vector; power of two, 2..256.
REQ-002 Parameter X_W, default 8, signed element width.
REQ-003 Parameter D_W, default 14, width of mean-square word sent to inv_sqrt.
REQ-004 Parameter OUT_FRAC, default 5, fractional bits of output (Q(X_W-OUT_FRAC).OUT_FRAC).
REQ-005 One clock; reset is asynchronous and active-low.
REQ-006 Port list SHALL be, in order:
  clk_i  in  1  clock;
  rst_ni  in  1  async active-low reset;
  valid_i  in  1  input element valid;
  ready_o  out  1  input element accepted when valid_i & ready_o;
  x_i  in  X_W  signed input element;
  isq_valid_o  out  1  one-cycle request pulse to inv_sqrt;
  isq_d_o  out  D_W  mean square to inv_sqrt;
  isq_valid_i  in  1  inv_sqrt result valid;
  isq_result_i  in  16  1/sqrt(d), 32768 = 1.0, 0xFFFF for d=0;
  valid_o  out  1  output element valid;
  ready_i  in  1  downstream ready;
  y_o  out  X_W  signed normalised element.

Function
REQ-007 FSM states SHALL be ACCUM, REQ, WAIT, EMIT; reset state ACCUM.
REQ-008 ACCUM: ready_o=1; each handshake stores x_i in buffer slot idx, adds x_i*x_i to sum, increments idx; after handshake with idx=VEC_LEN-1 -> REQ.
REQ-009 Sum register SHALL be 2*X_W-1+log2(VEC_LEN) bits, unsigned, cleared on entry to ACCUM; no overflow possible.
REQ-010 Mean SHALL be sum >> log2(VEC_LEN) (truncating), saturated to 2^D_W-1 if larger.
REQ-011 REQ: isq_valid_o=1 and isq_d_o=mean for exactly one cycle -> WAIT; isq_d_o SHALL hold its value until next REQ.
REQ-012 WAIT: on isq_valid_i=1 capture isq_result_i into r -> EMIT; isq_valid_i in any other state SHALL be ignored.
REQ-013 EMIT: elements emitted in input order, buffer slot 0 first; y = sat_X_W((x*r + 2^(14-OUT_FRAC)) >>> (15-OUT_FRAC)), x signed, r unsigned, signed product of X_W+17 bits.
REQ-014 Saturation SHALL clamp to [-2^(X_W-1), 2^(X_W-1)-1].
REQ-015 valid_o and y_o SHALL be registered; first valid_o rises the cycle after r is captured.
REQ-016 While valid_o=1 and ready_i=0, y_o and valid_o SHALL hold stable.
REQ-017 One element per cycle SHALL be emitted when ready_i stays 1 (no bubbles).
REQ-018 After handshake of element VEC_LEN-1: valid_o=0 next cycle, state -> ACCUM, ready_o=1 same next cycle.
REQ-019 ready_o SHALL be 0 in REQ, WAIT, EMIT; valid_i there is ignored.
REQ-020 Latency: isq_valid_o pulses exactly 1 cycle after the last input handshake.

Reset
REQ-021 On rst_ni=0, asynchronously: state=ACCUM, idx=0, sum=0, r=0, ready_o=0 during reset then 1 first cycle after release, isq_valid_o=0, isq_d_o=0, valid_o=0, y_o=0.
REQ-022 Reset mid-vector (any state) SHALL discard partial vector; buffer contents need no reset.

Structure
REQ-023 Package rmsnorm_pkg SHALL hold X_W, D_W, OUT_FRAC, VEC_LEN defaults, R_W=16, state enum.
REQ-024 Element buffer SHALL be sub-module vec_buf (VEC_LEN x X_W, one write port, one read port, registered read), inferable as distributed RAM.
REQ-025 inv_sqrt is not instantiated inside; integration connects isq_* ports.

Verification (bench models inv_sqrt with 2-cycle latency, VEC_LEN=64)
REQ-026 64 x (+16) -> isq_d_o=256; stub returns 2048 -> 64 outputs y=32.
REQ-027 Alternating +8/-8 -> isq_d_o=64; return 4096 -> y alternates 32/-32.
REQ-028 64 x (-128) -> isq_d_o=16383 (saturated); return 256 -> all y=-32.
REQ-029 64 x 0 -> isq_d_o=0; return 0xFFFF -> all y=0; spurious isq_valid_i during ACCUM ignored.
REQ-030 Vector of +16 with ready_i toggled 1/0 each cycle -> y_o stable while stalled, 64 outputs, order preserved, ready_o rises only after 64th handshake.
REQ-031 rst_ni pulsed low during EMIT at element 10 -> valid_o=0 immediately, next vector of +16 yields isq_d_o=256 and 64 correct outputs.
